// File: rtl/pic_core_pkg.sv
// pic_core_pkg: INTCON bit positions, interrupt FSM encoding and reg_idx bases
// shared by the PIC interrupt controller and its flag banks.
package pic_core_pkg;
    localparam int GIE_BIT  = 7;
    localparam int PEIE_BIT = 6;
    localparam int T0IE_BIT = 5;
    localparam int INTE_BIT = 4;
    localparam int RBIE_BIT = 3;
    localparam int T0IF_BIT = 2;
    localparam int INTF_BIT = 1;
    localparam int RBIF_BIT = 0;

    localparam int IDX_INTCON   = 0;
    localparam int IDX_PIR_BASE = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BND = 2'd1,
        ST_REQ      = 2'd2
    } state_t;
endpackage

// File: rtl/intc_flag_bank.sv
// intc_flag_bank: one 8-bit interrupt flag register; a set strobe beats a
// same-cycle software write so no peripheral event is ever lost.
module intc_flag_bank (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic [7:0] i_set,
    output logic [7:0] o_flags
);
    logic [7:0] r_flags;

    always_ff @(posedge clk) begin
        if (rst) r_flags <= '0;
        else     r_flags <= (i_wr_en ? i_wr_data : r_flags) | i_set;
    end

    assign o_flags = r_flags;
endmodule

// File: rtl/pic_interrupt_controller.sv
// pic_interrupt_controller: PIC-style INTCON/PIR/PIE registers and vector request FSM.
// Define INTC_SRC_CAPTURE_EN to add the irq_src capture of the winning source.
module pic_interrupt_controller
    import pic_core_pkg::*;
#(
    parameter int NUM_PIR_BANKS = 2,
    parameter int IDX_W         = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_boundary,
    input  logic                       reg_wr_en,
    input  logic [IDX_W-1:0]           reg_idx,
    input  logic [7:0]                 reg_wr_data,
    input  logic [8*NUM_PIR_BANKS-1:0] periph_strobes,
    input  logic                       tmr0if_set_en,
    input  logic                       intf_set_en,
    input  logic                       rbif_set_en,
    input  logic                       retfie,
    input  logic                       irq_ack,
    output logic [7:0]                 intcon_out,
    output logic [8*NUM_PIR_BANKS-1:0] pir_out,
    output logic [8*NUM_PIR_BANKS-1:0] pie_out,
    output logic                       interrupt_wake_up,
`ifdef INTC_SRC_CAPTURE_EN
    output logic [4:0]                 irq_src,
`endif
    output logic                       irq_req
);
    localparam int N    = NUM_PIR_BANKS;
    localparam int NSRC = 3 + 8 * N;

    logic [7:0]      r_intcon;
    logic [8*N-1:0]  r_pie;
    state_t          r_state;
    logic            r_irq_req;
    logic [7:0]      w_intcon_nxt;
    logic [8*N-1:0]  w_pir;
    logic [2:0]      w_core_pend;
    logic [8*N-1:0]  w_periph_pend;
    logic            w_wr_intcon;
    logic            w_ack;
    logic            w_gie;
    logic            w_wake;

    assign w_wr_intcon   = reg_wr_en && reg_idx == IDX_W'(IDX_INTCON);
    assign w_ack         = r_state == ST_REQ && irq_ack;
    assign w_gie         = r_intcon[GIE_BIT];
    assign w_core_pend   = {r_intcon[RBIE_BIT] & r_intcon[RBIF_BIT],
                            r_intcon[INTE_BIT] & r_intcon[INTF_BIT],
                            r_intcon[T0IE_BIT] & r_intcon[T0IF_BIT]};
    assign w_periph_pend = w_pir & r_pie & {(8*N){r_intcon[PEIE_BIT]}};
    assign w_wake        = |w_core_pend || |w_periph_pend;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_bank
            intc_flag_bank u_bank (
                .clk       (clk),
                .rst       (rst),
                .i_wr_en   (reg_wr_en && reg_idx == IDX_W'(IDX_PIR_BASE + k)),
                .i_wr_data (reg_wr_data),
                .i_set     (periph_strobes[8*k +: 8]),
                .o_flags   (w_pir[8*k +: 8])
            );
        end
    endgenerate

    // retfie owns GIE over both a software write and a same-cycle vector accept
    always_comb begin
        w_intcon_nxt           = w_wr_intcon ? reg_wr_data : r_intcon;
        w_intcon_nxt[T0IF_BIT] = w_intcon_nxt[T0IF_BIT] | tmr0if_set_en;
        w_intcon_nxt[INTF_BIT] = w_intcon_nxt[INTF_BIT] | intf_set_en;
        w_intcon_nxt[RBIF_BIT] = w_intcon_nxt[RBIF_BIT] | rbif_set_en;
        w_intcon_nxt[GIE_BIT]  = retfie | (w_intcon_nxt[GIE_BIT] & ~w_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) r_intcon <= '0;
        else     r_intcon <= w_intcon_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) r_pie <= '0;
        else
            for (int i = 0; i < N; i++)
                if (reg_wr_en && reg_idx == IDX_W'(IDX_PIR_BASE + N + i))
                    r_pie[8*i +: 8] <= reg_wr_data;
    end

`ifdef INTC_SRC_CAPTURE_EN
    logic [NSRC-1:0] w_pend;
    logic [4:0]      w_src;
    logic [4:0]      r_irq_src;

    assign w_pend = {w_periph_pend, w_core_pend};

    always_comb begin
        w_src = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_pend[i]) w_src = 5'(i);
    end

    assign irq_src = r_irq_src;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_irq_req <= 1'b0;
`ifdef INTC_SRC_CAPTURE_EN
            r_irq_src <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE:
                    if (w_wake && w_gie) r_state <= ST_WAIT_BND;
                ST_WAIT_BND:
                    if (!w_gie || !w_wake) r_state <= ST_IDLE;
                    else if (instr_boundary) begin
                        r_state   <= ST_REQ;
                        r_irq_req <= 1'b1;
`ifdef INTC_SRC_CAPTURE_EN
                        r_irq_src <= w_src;
`endif
                    end
                ST_REQ:
                    if (irq_ack) begin
                        r_state   <= ST_IDLE;
                        r_irq_req <= 1'b0;
                    end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign intcon_out        = r_intcon;
    assign pir_out           = w_pir;
    assign pie_out           = r_pie;
    assign interrupt_wake_up = w_wake;
    assign irq_req           = r_irq_req;
endmodule
